ysyx_idu_pipe: RTL and testbench
================================

// Module: ysyx_idu_pipe
// PURPOSE
// Registered RV32I instruction decode stage between IFU and EXU, with valid/ready handshakes on both sides.
// Decodes the full RV32I base set, and optionally the M extension, into the existing control encodings.
// A 2-entry output buffer (output register plus skid register) gives full throughput with registered in_ready.
// Reports illegal/ebreak/ecall as flags; the stage does not call into the simulator itself.
// PARAMETERS
// XLEN    32  datapath width; pc/imm width (32 only supported; 64 reserved)
// HAS_M   0   1: decode MUL/DIV/REM (op 0x33, funct7 0x01); 0: flag them illegal
// PORTS
// clk           in   1     clock, rising edge
// rst           in   1     synchronous, active-high reset
// flush         in   1     drop all buffered instructions (branch redirect)
// in_valid      in   1     IFU presents inst/pc
// in_ready      out  1     stage can accept; registered
// in_inst       in   32    instruction word
// in_pc         in   XLEN  instruction address
// out_valid     out  1     decoded bundle valid
// out_ready     in   1     EXU accepts bundle
// out_pc        out  XLEN  pc of bundle
// out_rd/rs1/rs2 out 5 ea  register indices (rd forced 0 when rf_wr_en=0)
// out_imm       out  XLEN  sign-extended I/S/B/U/J immediate, 0 for R-type
// rf_wr_en      out  1     writes rd
// rf_wr_sel     out  2     01 pc+4, 10 ALU, 11 load data, 00 none
// do_jump       out  1     jal/jalr
// br_type       out  3     010 beq 011 bne 100 blt 101 bge 110 bltu 111 bgeu, else 000
// alu_a_sel     out  1     1 rs1, 0 pc
// alu_b_sel     out  1     1 imm, 0 rs2
// alu_ctrl      out  4     0000 add 1000 sub 0001 sll 0010 slt 0011 sltu 0100 xor 0101 srl 1101 sra 0110 or 0111 and 1110 passB
// dm_rd_sel     out  3     001 lb 010 lbu 011 lh 100 lhu 101 lw, else 000
// dm_wr_sel     out  2     01 sb 10 sh 11 sw, else 00
// mdu_en        out  1     M-ext op (always 0 when HAS_M=0)
// mdu_op        out  3     funct3 of M-ext op
// illegal       out  1     unrecognised encoding
// is_ebreak     out  1     inst == 0x00100073
// is_ecall      out  1     inst == 0x00000073
// BEHAVIOUR
// - Reset: out_valid=0, in_ready=1, skid empty; all bundle outputs 0.
// - Accept on in_valid&in_ready; bundle appears on out_valid the next cycle (latency 1).
// - Transfer on out_valid&out_ready; bundle outputs stable while out_valid&!out_ready.
// - Occupancy 0..2: out_reg holds oldest, skid holds second; in_ready = !skid_full (registered).
// - Accept while out_reg full and not draining -> skid. Drain with skid full -> skid moves to out_reg same edge.
// - Accept and drain in same cycle with skid empty -> new bundle into out_reg; no bubble.
// - Full throughput 1 inst/cycle when out_ready held high.
// - flush (priority over everything but rst): next cycle occupancy 0, out_valid=0, in_ready=1; inst presented in the flush cycle is discarded.
// - Decode is combinational on in_inst, registered at accept; arithmetic: imm sign-extended from inst[31].
// - Loads: alu add, a=rs1, b=imm, rf_wr_sel 11. Stores: alu add, rf_wr_en=0. Branches: alu add, a=pc, b=imm.
// - lui: passB, rf_wr_sel 10; auipc: add, a=pc. jal: a=pc; jalr: a=rs1; both rf_wr_sel 01.
// - fence decodes as legal no-op (rf_wr_en=0). csr ops (op 0x73, funct3!=0) illegal.
// - illegal/ebreak/ecall bundles: rf_wr_en=0, dm_wr_sel=00, do_jump=0, br_type=000; still handshaked as normal.
// - srai/srli/slli with inst[31:25] not 0x00/0x20 (per op) -> illegal.
// TESTING
// - rst, then addi x1,x0,5 (0x00500093) valid, out_ready=1 -> next cycle out_valid=1, imm=5, alu_ctrl=0000, rf_wr_sel=10, rd=1.
// - 3 back-to-back insts, out_ready=0 -> in_ready drops after 2nd accept; release -> all 3 emerge in order, no loss/dup.
// - flush with occupancy 2 and in_valid=1 -> next cycle out_valid=0, in_ready=1; none of the 3 insts ever emerge.
// - mul x3,x1,x2 (0x022081B3): HAS_M=1 -> mdu_en=1, mdu_op=000; HAS_M=0 -> illegal=1, rf_wr_en=0.
// - 0x00100073 -> is_ebreak=1; 0xFFFFFFFF -> illegal=1; both with dm_wr_sel=00.
// - sw x2,-4(x1) (0xFE20AE23) -> imm=0xFFFFFFFC, dm_wr_sel=11, rf_wr_en=0; beq -> br_type=010, alu_a_sel=0.

Source files
------------

// File: rtl/ysyx_idu_pipe.sv
// ysyx_idu_pipe: registered RV32I (+ optional M) decode stage between IFU and EXU.
// A decoded bundle is captured at accept and held in a two-entry buffer
// (output register + skid register), so in_ready can be a flop and the stage
// still sustains one instruction per cycle.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   flush              drop every buffered bundle and the one offered this cycle
//   in_valid/in_ready  IFU handshake (in_ready registered)
//   in_inst, in_pc     instruction word and its address
//   out_valid/out_ready EXU handshake
//   out_pc, out_rd, out_rs1, out_rs2, out_imm   bundle operands
//   rf_wr_en, rf_wr_sel, do_jump, br_type, alu_a_sel, alu_b_sel, alu_ctrl,
//   dm_rd_sel, dm_wr_sel, mdu_en, mdu_op        bundle control
//   illegal, is_ebreak, is_ecall                exception flags
module ysyx_idu_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter bit          HAS_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            rf_wr_en,
  output logic [1:0]      rf_wr_sel,
  output logic            do_jump,
  output logic [2:0]      br_type,
  output logic            alu_a_sel,
  output logic            alu_b_sel,
  output logic [3:0]      alu_ctrl,
  output logic [2:0]      dm_rd_sel,
  output logic [1:0]      dm_wr_sel,
  output logic            mdu_en,
  output logic [2:0]      mdu_op,
  output logic            illegal,
  output logic            is_ebreak,
  output logic            is_ecall
);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_PASSB = 4'b1110;

  localparam logic [1:0] WB_PC4  = 2'b01;
  localparam logic [1:0] WB_ALU  = 2'b10;
  localparam logic [1:0] WB_LOAD = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            rf_wr_en;
    logic [1:0]      rf_wr_sel;
    logic            do_jump;
    logic [2:0]      br_type;
    logic            alu_a_sel;
    logic            alu_b_sel;
    logic [3:0]      alu_ctrl;
    logic [2:0]      dm_rd_sel;
    logic [1:0]      dm_wr_sel;
    logic            mdu_en;
    logic [2:0]      mdu_op;
    logic            illegal;
    logic            is_ebreak;
    logic            is_ecall;
  } bundle_t;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  bundle_t         w_dec;

  bundle_t r_out;
  bundle_t r_skid;
  logic    r_out_valid;
  logic    r_skid_valid;
  logic    r_in_ready;

  logic w_accept;
  logic w_drain;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];
  assign w_funct7 = in_inst[31:25];

  // Immediates, all sign-extended from inst[31]
  assign w_imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'h000};
  assign w_imm_j = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Combinational decode of the offered instruction
  always_comb begin
    w_dec     = '0;
    w_dec.pc  = in_pc;
    w_dec.rs1 = in_inst[19:15];
    w_dec.rs2 = in_inst[24:20];
    w_dec.rd  = in_inst[11:7];

    unique case (w_opcode)
      OP_LUI: begin
        w_dec.imm       = w_imm_u;
        w_dec.rf_wr_en  = 1'b1;
        w_dec.rf_wr_sel = WB_ALU;
        w_dec.alu_b_sel = 1'b1;
        w_dec.alu_ctrl  = ALU_PASSB;
      end
      OP_AUIPC: begin
        w_dec.imm       = w_imm_u;
        w_dec.rf_wr_en  = 1'b1;
        w_dec.rf_wr_sel = WB_ALU;
        w_dec.alu_b_sel = 1'b1;
        w_dec.alu_ctrl  = ALU_ADD;
      end
      OP_JAL: begin
        w_dec.imm       = w_imm_j;
        w_dec.rf_wr_en  = 1'b1;
        w_dec.rf_wr_sel = WB_PC4;
        w_dec.do_jump   = 1'b1;
        w_dec.alu_b_sel = 1'b1;
      end
      OP_JALR: begin
        w_dec.imm       = w_imm_i;
        w_dec.rf_wr_en  = 1'b1;
        w_dec.rf_wr_sel = WB_PC4;
        w_dec.do_jump   = 1'b1;
        w_dec.alu_a_sel = 1'b1;
        w_dec.alu_b_sel = 1'b1;
        w_dec.illegal   = (w_funct3 != 3'b000);
      end
      OP_BRANCH: begin
        w_dec.imm       = w_imm_b;
        w_dec.alu_b_sel = 1'b1;
        unique case (w_funct3)
          3'b000:  w_dec.br_type = 3'b010;
          3'b001:  w_dec.br_type = 3'b011;
          3'b100, 3'b101, 3'b110, 3'b111: w_dec.br_type = w_funct3;
          default: w_dec.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_dec.imm       = w_imm_i;
        w_dec.rf_wr_en  = 1'b1;
        w_dec.rf_wr_sel = WB_LOAD;
        w_dec.alu_a_sel = 1'b1;
        w_dec.alu_b_sel = 1'b1;
        unique case (w_funct3)
          3'b000:  w_dec.dm_rd_sel = 3'b001;
          3'b100:  w_dec.dm_rd_sel = 3'b010;
          3'b001:  w_dec.dm_rd_sel = 3'b011;
          3'b101:  w_dec.dm_rd_sel = 3'b100;
          3'b010:  w_dec.dm_rd_sel = 3'b101;
          default: w_dec.illegal   = 1'b1;
        endcase
      end
      OP_STORE: begin
        w_dec.imm       = w_imm_s;
        w_dec.alu_a_sel = 1'b1;
        w_dec.alu_b_sel = 1'b1;
        unique case (w_funct3)
          3'b000:  w_dec.dm_wr_sel = 2'b01;
          3'b001:  w_dec.dm_wr_sel = 2'b10;
          3'b010:  w_dec.dm_wr_sel = 2'b11;
          default: w_dec.illegal   = 1'b1;
        endcase
      end
      OP_IMM: begin
        w_dec.imm       = w_imm_i;
        w_dec.rf_wr_en  = 1'b1;
        w_dec.rf_wr_sel = WB_ALU;
        w_dec.alu_a_sel = 1'b1;
        w_dec.alu_b_sel = 1'b1;
        unique case (w_funct3)
          3'b001: begin
            w_dec.alu_ctrl = ALU_SLL;
            w_dec.illegal  = (w_funct7 != 7'h00);
          end
          3'b101: begin
            // funct7 selects logical vs arithmetic shift; anything else is reserved
            if (w_funct7 == 7'h00)      w_dec.alu_ctrl = ALU_SRL;
            else if (w_funct7 == 7'h20) w_dec.alu_ctrl = ALU_SRA;
            else                        w_dec.illegal  = 1'b1;
          end
          default: w_dec.alu_ctrl = {1'b0, w_funct3};
        endcase
      end
      OP_REG: begin
        w_dec.rf_wr_en  = 1'b1;
        w_dec.rf_wr_sel = WB_ALU;
        w_dec.alu_a_sel = 1'b1;
        if (w_funct7 == 7'h00) begin
          w_dec.alu_ctrl = {1'b0, w_funct3};
        end else if (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
          w_dec.alu_ctrl = {1'b1, w_funct3};
        end else if (w_funct7 == 7'h01 && HAS_M) begin
          w_dec.mdu_en = 1'b1;
          w_dec.mdu_op = w_funct3;
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      OP_FENCE: begin
        w_dec.imm     = w_imm_i;
        w_dec.illegal = (w_funct3 != 3'b000);
      end
      OP_SYSTEM: begin
        w_dec.imm = w_imm_i;
        if (in_inst == 32'h0000_0073)      w_dec.is_ecall  = 1'b1;
        else if (in_inst == 32'h0010_0073) w_dec.is_ebreak = 1'b1;
        else                               w_dec.illegal   = 1'b1;
      end
      default: w_dec.illegal = 1'b1;
    endcase

    // Trapping bundles must not cause any architectural side effect
    if (w_dec.illegal || w_dec.is_ecall || w_dec.is_ebreak) begin
      w_dec.rf_wr_en  = 1'b0;
      w_dec.rf_wr_sel = 2'b00;
      w_dec.do_jump   = 1'b0;
      w_dec.br_type   = 3'b000;
      w_dec.dm_rd_sel = 3'b000;
      w_dec.dm_wr_sel = 2'b00;
      w_dec.mdu_en    = 1'b0;
      w_dec.mdu_op    = 3'b000;
    end

    if (!w_dec.rf_wr_en) begin
      w_dec.rd = 5'd0;
    end
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;

  // Output register + skid buffer; skid only fills while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (r_out_valid && !w_drain) begin
      if (w_accept) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end else if (r_skid_valid) begin
      // in_ready is low whenever skid is full, so nothing new arrives here
      r_out        <= r_skid;
      r_out_valid  <= 1'b1;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_accept) begin
      r_out       <= w_dec;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_pc    = r_out.pc;
  assign out_rd    = r_out.rd;
  assign out_rs1   = r_out.rs1;
  assign out_rs2   = r_out.rs2;
  assign out_imm   = r_out.imm;
  assign rf_wr_en  = r_out.rf_wr_en;
  assign rf_wr_sel = r_out.rf_wr_sel;
  assign do_jump   = r_out.do_jump;
  assign br_type   = r_out.br_type;
  assign alu_a_sel = r_out.alu_a_sel;
  assign alu_b_sel = r_out.alu_b_sel;
  assign alu_ctrl  = r_out.alu_ctrl;
  assign dm_rd_sel = r_out.dm_rd_sel;
  assign dm_wr_sel = r_out.dm_wr_sel;
  assign mdu_en    = r_out.mdu_en;
  assign mdu_op    = r_out.mdu_op;
  assign illegal   = r_out.illegal;
  assign is_ebreak = r_out.is_ebreak;
  assign is_ecall  = r_out.is_ecall;

endmodule

// File: tb/tb_ysyx_idu_pipe.sv
// Directed testbench for ysyx_idu_pipe: one DUT without and one with the M extension,
// both driven by the same stimulus.
module tb_ysyx_idu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid, rf_wr_en, do_jump, alu_a_sel, alu_b_sel;
  logic        mdu_en, illegal, is_ebreak, is_ecall;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [1:0]  rf_wr_sel, dm_wr_sel;
  logic [2:0]  br_type, dm_rd_sel, mdu_op;
  logic [3:0]  alu_ctrl;

  logic        m_in_ready, m_out_valid, m_rf_wr_en, m_do_jump, m_alu_a_sel, m_alu_b_sel;
  logic        m_mdu_en, m_illegal, m_is_ebreak, m_is_ecall;
  logic [31:0] m_out_pc, m_out_imm;
  logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
  logic [1:0]  m_rf_wr_sel, m_dm_wr_sel;
  logic [2:0]  m_br_type, m_dm_rd_sel, m_mdu_op;
  logic [3:0]  m_alu_ctrl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_idu_pipe #(.XLEN(32), .HAS_M(1'b0)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .do_jump(do_jump),
    .br_type(br_type), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl),
    .dm_rd_sel(dm_rd_sel), .dm_wr_sel(dm_wr_sel), .mdu_en(mdu_en), .mdu_op(mdu_op),
    .illegal(illegal), .is_ebreak(is_ebreak), .is_ecall(is_ecall)
  );

  ysyx_idu_pipe #(.XLEN(32), .HAS_M(1'b1)) u_dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_out_pc), .out_rd(m_out_rd), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2),
    .out_imm(m_out_imm), .rf_wr_en(m_rf_wr_en), .rf_wr_sel(m_rf_wr_sel), .do_jump(m_do_jump),
    .br_type(m_br_type), .alu_a_sel(m_alu_a_sel), .alu_b_sel(m_alu_b_sel), .alu_ctrl(m_alu_ctrl),
    .dm_rd_sel(m_dm_rd_sel), .dm_wr_sel(m_dm_wr_sel), .mdu_en(m_mdu_en), .mdu_op(m_mdu_op),
    .illegal(m_illegal), .is_ebreak(m_is_ebreak), .is_ecall(m_is_ecall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for a single cycle; outputs then show its bundle
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (out_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got=%h exp=0", out_imm); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%0h exp=0", illegal); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    send(32'h0050_0093, 32'h8000_0000);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%0h exp=1", out_valid); end
    checks++; if (out_imm !== 32'd5) begin errors++; $display("FAIL addi_imm got=%h exp=5", out_imm); end
    checks++; if (alu_ctrl !== 4'b0000) begin errors++; $display("FAIL addi_alu got=%b exp=0000", alu_ctrl); end
    checks++; if (rf_wr_sel !== 2'b10) begin errors++; $display("FAIL addi_wrsel got=%b exp=10", rf_wr_sel); end
    checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got=%0d exp=1", out_rd); end
    checks++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL addi_pc got=%h exp=80000000", out_pc); end
    checks++; if ({alu_a_sel, alu_b_sel, rf_wr_en} !== 3'b111) begin errors++; $display("FAIL addi_sel got=%b exp=111", {alu_a_sel, alu_b_sel, rf_wr_en}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drained got=%0h exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst = 32'h0050_0093; in_pc = 32'h100; tick();
    checks++; if ({out_valid, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_first got=%b exp=11", {out_valid, in_ready}); end
    in_inst = 32'h0050_0113; in_pc = 32'h104; tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%0h exp=0", in_ready); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL b2b_hold_pc got=%h exp=100", out_pc); end
    in_inst = 32'h0050_0193; in_pc = 32'h108; tick();
    checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL b2b_stall got=%b exp=10", {out_valid, in_ready}); end
    checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL b2b_hold_rd got=%0d exp=1", out_rd); end
    out_ready = 1'b1; tick();
    checks++; if (out_pc !== 32'h104 || out_rd !== 5'd2) begin errors++; $display("FAIL b2b_second got=%h/%0d exp=104/2", out_pc, out_rd); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h108 || out_rd !== 5'd3) begin errors++; $display("FAIL b2b_third got=%0h/%h/%0d exp=1/108/3", out_valid, out_pc, out_rd); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%0h exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst = 32'h0050_0093; in_pc = 32'h200; tick();
    in_pc = 32'h204; tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull got=%0h exp=0", in_ready); end
    in_pc = 32'h208; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_state got=%b exp=01", {out_valid, in_ready}); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak cycle=%0d got=%0h pc=%h exp=0", i, out_valid, out_pc); end
    end
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    send(32'h0220_81B3, 32'h300);
    checks++; if ({m_mdu_en, m_mdu_op} !== 4'b1000) begin errors++; $display("FAIL mul_m_mdu got=%b exp=1000", {m_mdu_en, m_mdu_op}); end
    checks++; if ({m_illegal, m_rf_wr_en, m_out_rd} !== 7'b0100011) begin errors++; $display("FAIL mul_m_wb got=%b exp=0100011", {m_illegal, m_rf_wr_en, m_out_rd}); end
    checks++; if ({illegal, rf_wr_en, mdu_en} !== 3'b100) begin errors++; $display("FAIL mul_nom got=%b exp=100", {illegal, rf_wr_en, mdu_en}); end
    checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL mul_nom_rd got=%0d exp=0", out_rd); end
  endtask

  task automatic test_system();
    out_ready = 1'b1;
    send(32'h0010_0073, 32'h400);
    checks++; if ({is_ebreak, is_ecall, illegal, dm_wr_sel, rf_wr_en} !== 6'b100000) begin errors++; $display("FAIL ebreak got=%b exp=100000", {is_ebreak, is_ecall, illegal, dm_wr_sel, rf_wr_en}); end
    send(32'h0000_0073, 32'h404);
    checks++; if ({is_ebreak, is_ecall, illegal} !== 3'b010) begin errors++; $display("FAIL ecall got=%b exp=010", {is_ebreak, is_ecall, illegal}); end
    send(32'hFFFF_FFFF, 32'h408);
    checks++; if ({out_valid, illegal, dm_wr_sel, rf_wr_en, do_jump} !== 6'b110000) begin errors++; $display("FAIL allones got=%b exp=110000", {out_valid, illegal, dm_wr_sel, rf_wr_en, do_jump}); end
    send(32'h3000_2573, 32'h40C);
    checks++; if ({illegal, is_ecall, rf_wr_en} !== 3'b100) begin errors++; $display("FAIL csr got=%b exp=100", {illegal, is_ecall, rf_wr_en}); end
  endtask

  task automatic test_store_branch();
    out_ready = 1'b1;
    send(32'hFE20_AE23, 32'h500);
    checks++; if (out_imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL sw_imm got=%h exp=fffffffc", out_imm); end
    checks++; if ({dm_wr_sel, rf_wr_en, out_rd} !== 8'b11000000) begin errors++; $display("FAIL sw_ctl got=%b exp=11000000", {dm_wr_sel, rf_wr_en, out_rd}); end
    checks++; if ({alu_ctrl, alu_a_sel, alu_b_sel} !== 6'b000011) begin errors++; $display("FAIL sw_alu got=%b exp=000011", {alu_ctrl, alu_a_sel, alu_b_sel}); end
    send(32'h0020_8463, 32'h504);
    checks++; if (br_type !== 3'b010) begin errors++; $display("FAIL beq_type got=%b exp=010", br_type); end
    checks++; if ({alu_a_sel, alu_b_sel, rf_wr_en, do_jump} !== 4'b0100) begin errors++; $display("FAIL beq_sel got=%b exp=0100", {alu_a_sel, alu_b_sel, rf_wr_en, do_jump}); end
    checks++; if (out_imm !== 32'd8) begin errors++; $display("FAIL beq_imm got=%h exp=8", out_imm); end
  endtask

  task automatic test_misc_decode();
    out_ready = 1'b1;
    send(32'h1234_52B7, 32'h600);
    checks++; if (out_imm !== 32'h1234_5000 || alu_ctrl !== 4'b1110 || rf_wr_sel !== 2'b10 || out_rd !== 5'd5) begin errors++; $display("FAIL lui got=%h/%b/%b/%0d exp=12345000/1110/10/5", out_imm, alu_ctrl, rf_wr_sel, out_rd); end
    send(32'h0100_00EF, 32'h604);
    checks++; if ({do_jump, rf_wr_sel, alu_a_sel} !== 4'b1010 || out_imm !== 32'd16 || out_rd !== 5'd1) begin errors++; $display("FAIL jal got=%b/%h/%0d exp=1010/10/1", {do_jump, rf_wr_sel, alu_a_sel}, out_imm, out_rd); end
    send(32'h4020_81B3, 32'h608);
    checks++; if ({alu_ctrl, alu_b_sel} !== 5'b10000) begin errors++; $display("FAIL sub got=%b exp=10000", {alu_ctrl, alu_b_sel}); end
    send(32'h4030_D093, 32'h60C);
    checks++; if ({alu_ctrl, illegal} !== 5'b11010) begin errors++; $display("FAIL srai got=%b exp=11010", {alu_ctrl, illegal}); end
    send(32'h4030_9093, 32'h610);
    checks++; if ({illegal, rf_wr_en} !== 2'b10) begin errors++; $display("FAIL bad_slli got=%b exp=10", {illegal, rf_wr_en}); end
    send(32'h0081_2283, 32'h614);
    checks++; if ({dm_rd_sel, rf_wr_sel} !== 5'b10111 || out_imm !== 32'd8) begin errors++; $display("FAIL lw got=%b/%h exp=10111/8", {dm_rd_sel, rf_wr_sel}, out_imm); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_flush();
    test_mul();
    test_system();
    test_store_branch();
    test_misc_decode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
